// File: rtl/stream_pool_stage_pkg.sv
// Shared definitions for the stream pooling stage: mode encodings and window log2 helper.
package stream_pool_stage_pkg;

  localparam int unsigned MODE_MAX = 0;
  localparam int unsigned MODE_AVG = 1;

  // log2 of the pooling window size (exact for powers of two)
  function automatic int unsigned clog2k(input int unsigned k);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < k) r++;
    return r;
  endfunction

endpackage

// File: rtl/stream_pool_stage_lane.sv
// One channel lane: horizontal window combine, line-buffer vertical combine, final scaling.
module pool_lane
  import stream_pool_stage_pkg::*;
#(
  parameter int unsigned DW    = 9,
  parameter int unsigned K     = 2,
  parameter int unsigned IMG_W = 28,
  parameter int unsigned MODE  = MODE_MAX,
  parameter int unsigned SW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          first,
  input  logic          last,
  input  logic          row0,
  input  logic          rowlast,
  input  logic [SW-1:0] slot,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  localparam int unsigned L     = clog2k(K);
  localparam int unsigned AW    = DW + 2 * L;
  localparam int unsigned NSLOT = IMG_W / K;

  logic signed [AW-1:0] hacc;
  logic signed [AW-1:0] x_c, part_c, vert_c, scaled_c;
  logic signed [AW-1:0] lbuf [NSLOT];

  function automatic logic signed [AW-1:0] combine(input logic signed [AW-1:0] a,
                                                   input logic signed [AW-1:0] b);
    if (MODE == MODE_AVG) return a + b;
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    x_c      = AW'($signed(din));
    part_c   = first ? x_c : combine(hacc, x_c);
    vert_c   = combine(lbuf[slot], part_c);
    scaled_c = (MODE == MODE_AVG) ? (vert_c >>> (2 * L)) : vert_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hacc <= '0;
      dout <= '0;
    end else if (en) begin
      hacc <= part_c;
      if (last && rowlast) dout <= DW'(scaled_c);
    end
  end

  // Line buffer is deliberately unreset: the first window row always overwrites a slot before use
  always_ff @(posedge clk) begin
    if (en && last && !rowlast) lbuf[slot] <= row0 ? part_c : vert_c;
  end

endmodule

// File: rtl/stream_pool_stage.sv
// KxK stride-K pooling over a raster pixel stream, NCH lanes sharing one column/row control path.
module stream_pool_stage
  import stream_pool_stage_pkg::*;
#(
  parameter int unsigned DW    = 9,
  parameter int unsigned NCH   = 6,
  parameter int unsigned IMG_W = 28,
  parameter int unsigned K     = 2,
  parameter int unsigned MODE  = MODE_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [NCH*DW-1:0] in_data,
  output logic              out_valid,
  output logic [NCH*DW-1:0] out_data,
  output logic              out_row_end
);

  localparam int unsigned L     = clog2k(K);
  localparam int unsigned NSLOT = IMG_W / K;
  localparam int unsigned USED  = NSLOT * K;
  localparam int unsigned CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned SW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  logic [CW-1:0] col, col_c;
  logic [L-1:0]  wr, wr_c;
  logic [SW-1:0] slot_c;
  logic          sof_c, en_c, first_c, last_c, row0_c, rowlast_c, fire_c;

  // A start-of-frame beat restarts the raster position, dropping any partial window
  always_comb begin
    sof_c     = in_valid && in_sof;
    col_c     = sof_c ? '0 : col;
    wr_c      = sof_c ? '0 : wr;
    slot_c    = SW'(col_c >> L);
    first_c   = (col_c[L-1:0] == '0);
    last_c    = (col_c[L-1:0] == L'(K - 1));
    row0_c    = (wr_c == '0);
    rowlast_c = (wr_c == L'(K - 1));
    en_c      = in_valid && (32'(col_c) < USED);
    fire_c    = en_c && last_c && rowlast_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col         <= '0;
      wr          <= '0;
      out_valid   <= 1'b0;
      out_row_end <= 1'b0;
    end else begin
      out_valid   <= fire_c;
      out_row_end <= fire_c && (slot_c == SW'(NSLOT - 1));
      if (in_valid) begin
        if (col_c == CW'(IMG_W - 1)) begin
          col <= '0;
          wr  <= rowlast_c ? '0 : wr_c + L'(1);
        end else begin
          col <= col_c + CW'(1);
          wr  <= wr_c;
        end
      end
    end
  end

  for (genvar n = 0; n < NCH; n++) begin : g_lane
    pool_lane #(
      .DW   (DW),
      .K    (K),
      .IMG_W(IMG_W),
      .MODE (MODE),
      .SW   (SW)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .en     (en_c),
      .first  (first_c),
      .last   (last_c),
      .row0   (row0_c),
      .rowlast(rowlast_c),
      .slot   (slot_c),
      .din    (in_data[n*DW +: DW]),
      .dout   (out_data[n*DW +: DW])
    );
  end

endmodule

// File: doc/stream_pool_stage.md
STREAM_POOL_STAGE -- requirements
Module: stream_pool_stage

Interface
REQ-001 SHALL have parameter DW, default 9: signed sample width per channel.
REQ-002 SHALL have parameter NCH, default 6: parallel channel lanes sharing one control path.
REQ-003 SHALL have parameter IMG_W, default 28: input pixels per row.
REQ-004 SHALL have parameter K, default 2: pooling window and stride; legal values 2 and 4.
REQ-005 SHALL have parameter MODE, default 0: 0 selects max pooling, 1 selects average pooling.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port in_valid, input, 1: in_data carries one pixel per lane this cycle.
REQ-009 SHALL have port in_sof, input, 1: qualified by in_valid; the current beat is pixel (0,0) of a new frame.
REQ-010 SHALL have port in_data, input, NCH*DW: lane n in bits [n*DW +: DW], signed.
REQ-011 SHALL have port out_valid, output, 1: out_data holds one pooled result per lane.
REQ-012 SHALL have port out_data, output, NCH*DW: pooled lanes, same packing as in_data.
REQ-013 SHALL have port out_row_end, output, 1: high with out_valid on the last pooled column of a row.

Function
REQ-014 SHALL keep column counter col (0..IMG_W-1) and window-row counter wr (0..K-1), advancing only on in_valid beats; col wraps to 0 and wr increments mod K at col==IMG_W-1.
REQ-015 SHALL hold all state unchanged on cycles with in_valid low; idle gaps of any length are legal.
REQ-016 SHALL treat in_valid&&in_sof as col=0, wr=0, discarding any partial window in progress.
REQ-017 SHALL per lane combine K consecutive row pixels into a horizontal partial: max (MODE 0) or signed sum (MODE 1).
REQ-018 SHALL at col%K==K-1 store the partial in line-buffer slot col/K when wr==0, else combine it with the stored slot value.
REQ-019 SHALL ignore columns col >= (IMG_W/K)*K; they never contribute to any output.
REQ-020 SHALL line-buffer depth equal IMG_W/K entries of NCH*(DW+2*log2(K)) bits.
REQ-021 SHALL on the beat completing a KxK window (wr==K-1, col%K==K-1) assert out_valid exactly one cycle later for one cycle; no output at any other time.
REQ-022 SHALL in MODE 0 output the signed maximum of the K*K samples.
REQ-023 SHALL in MODE 1 accumulate at DW+2*log2(K) bits without overflow and output the sum arithmetic-shifted right by 2*log2(K) (floor toward minus infinity).
REQ-024 SHALL assert out_row_end with out_valid when the completing slot is IMG_W/K-1.
REQ-025 SHALL hold out_data at its last value while out_valid is low.
REQ-026 SHALL produce no output for a window split by in_sof; the new frame starts cleanly.
REQ-027 SHALL have no gated clocks; in_valid acts as a clock enable.

Reset
REQ-028 SHALL on reset low asynchronously clear col, wr, lane accumulators, out_valid, out_row_end and out_data to 0.
REQ-029 SHALL leave the line-buffer contents unreset; wr==0 writes always overwrite them before they are read.
REQ-030 SHALL, when reset is asserted mid-frame, discard all in-flight windows; the first post-reset beat is pixel (0,0) whether or not in_sof is set.

Structure
REQ-031 SHALL place the MODE encodings and the log2 helper for K in a shared package.
REQ-032 SHALL instantiate sub-module pool_lane NCH times (horizontal accumulate, combine and final shift); counters and slot addressing are shared in the top level.

Verification
REQ-033 SHALL check: NCH=1, K=2, IMG_W=4, MODE 0, rows {1,5,-3,2} and {4,0,7,-8} -> outputs 5, then 7 with out_row_end, each one cycle after its completing beat.
REQ-034 SHALL check: the same data in MODE 1 -> outputs 2 (10>>2) and -1 (-2>>2 floor).
REQ-035 SHALL check: IMG_W=5, K=2 -> column 4 ignored; 2 outputs per row pair; out_row_end on the 2nd.
REQ-036 SHALL check: random in_valid gaps (50% duty) -> output sequence identical to the gap-free run.
REQ-037 SHALL check: in_sof after 1.5 rows -> no output from the partial rows; next frame output correct.
REQ-038 SHALL check: reset pulsed low mid-row -> all outputs 0 immediately; restart output matches a clean run; all-negative input (-256 everywhere, DW=9) -> max -256, avg -256.
